mem_stage: RTL and testbench
============================

Name: mem_stage

Overview:
- Consumer end of the EX/MEM pipeline interface in the pipelined RV32 core.
- Takes the registered EX/MEM control and data bundle and performs the data-memory access over a req/ack bus.
- Stalls the upstream pipeline while the access is outstanding.
- Resolves taken branches and registers results into the MEM/WB stage.

Parameters:
- TIMEOUT, 16, max WAIT cycles without dmem_ack before the access is aborted.
- CNT_W, 5, timeout counter width; must hold TIMEOUT.

Ports:
- clk  input  1  core clock
- reset  input  1  asynchronous, active-high reset
- mem_re_in  input  1  load request from EX/MEM
- mem_we_in  input  1  store request from EX/MEM
- reg_file_write_in  input  1  writeback enable from EX/MEM
- branch_in  input  1  branch condition true (ALU flag)
- branch_instruction_in  input  1  instruction is a branch
- select_mux_2_in  input  2  PC-source select, passed through
- select_mux_4_in  input  2  writeback mux select
- reg_b_in  input  32  store data
- addr_rd_in  input  5  destination register
- alu_in  input  32  ALU result / memory address
- add_pc_in  input  32  branch target / PC+4 value
- dmem_req  output  1  bus request
- dmem_we  output  1  bus write strobe
- dmem_addr  output  32  word address
- dmem_wdata  output  32  store data
- dmem_rdata  input  32  load data, valid with ack
- dmem_ack  input  1  access complete
- stall  output  1  hold PC, IF/ID, ID/EX, EX/MEM
- pc_src  output  1  taken branch
- branch_target  output  32  equals add_pc_in
- wb_valid  output  1  MEM/WB holds a real instruction
- reg_file_write_out  output  1
- select_mux_4_out  output  2
- addr_rd_out  output  5
- alu_out  output  32
- mem_data_out  output  32
- add_pc_out  output  32
- bus_error  output  1  sticky: timeout occurred
- misalign_error  output  1  sticky: misaligned access dropped

Behaviour:
- Reset (async, active-high): FSM=IDLE, counter=0, all registered outputs 0, dmem_req=0, stall=0, both error flags 0. Reset during WAIT drops dmem_req immediately and abandons the access; no MEM/WB write.
- access = mem_re_in | mem_we_in. Both set is illegal; treat as a store.
- FSM states: IDLE, WAIT.
- IDLE, access, alu_in[1:0]==0:
  - latch addr, wdata and we; go to WAIT; stall=1 combinationally.
  - MEM/WB loads a bubble (wb_valid=0, reg_file_write_out=0).
- IDLE, access, alu_in[1:0]!=0:
  - no bus request; set misalign_error; MEM/WB bubble; stall=0.
- IDLE, no access:
  - MEM/WB loads the input bundle next edge: wb_valid=1, mem_data_out=0; stall=0. One-cycle latency.
- WAIT:
  - dmem_req=1; dmem_addr, dmem_we and dmem_wdata come from the latched values and are stable until ack.
  - Counter increments each WAIT cycle without ack.
- WAIT, dmem_ack:
  - stall=0 that cycle; next edge MEM/WB loads the bundle with mem_data_out=dmem_rdata (loads) or 0 (stores); wb_valid=1; go to IDLE; counter cleared.
  - Minimum memory latency is 2 cycles.
- WAIT, counter==TIMEOUT-1 without ack:
  - set bus_error; MEM/WB bubble; go to IDLE; stall=0; dmem_req drops next cycle. A late ack arriving in IDLE is ignored.
- pc_src = branch_instruction_in & branch_in & (state==IDLE). Combinational; never asserted during a stall.
- Stores: reg_file_write_out forced 0 in MEM/WB.
- Sticky flags clear only on reset.

Decomposition:
- Shared package core_pkg:
  - state enum {IDLE, WAIT}
  - select_mux_4 encodings: ALU=2'b00, MEM=2'b01, PC=2'b10
  - XLEN=32
- Sub-module mem_wb_reg: plain MEM/WB register with async reset and a bubble input. The FSM and bus logic stay in mem_stage.

Test Plan:
- ALU op, alu_in=0x1234, addr_rd_in=5, reg_file_write_in=1, no access -> next edge wb_valid=1, alu_out=0x1234, addr_rd_out=5, stall never high.
- Load at 0x100, ack on 3rd WAIT cycle with rdata=0xDEADBEEF -> stall high 3 cycles, dmem_addr=0x100 stable, then mem_data_out=0xDEADBEEF, wb_valid=1.
- Store 0xCAFEF00D to 0x40, ack in first WAIT cycle -> dmem_we=1, dmem_wdata=0xCAFEF00D, stall high exactly 1 cycle, reg_file_write_out=0.
- Load with no ack, TIMEOUT=16 -> bus_error=1 after 16 WAIT cycles, MEM/WB bubble, stall released; a later ack is ignored.
- Branch, branch_in=1, add_pc_in=0x80 -> pc_src=1, branch_target=0x80 same cycle; with branch_in=0 -> pc_src=0.
- Load to alu_in=0x102 -> no dmem_req, misalign_error=1, bubble. Reset asserted mid-WAIT -> dmem_req=0 immediately, all outputs 0.

Source files
------------

// File: rtl/core_pkg.sv
// Shared types and constants for the pipelined RV32 core.
package core_pkg;

  localparam int XLEN = 32;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } state_e;

  // Writeback mux select encodings carried through MEM/WB.
  typedef enum logic [1:0] {
    WB_ALU = 2'b00,
    WB_MEM = 2'b01,
    WB_PC  = 2'b10
  } wb_sel_e;

  typedef struct packed {
    logic            reg_file_write;
    logic [1:0]      select_mux_4;
    logic [4:0]      addr_rd;
    logic [XLEN-1:0] alu;
    logic [XLEN-1:0] mem_data;
    logic [XLEN-1:0] add_pc;
  } wb_bundle_t;

  function automatic logic misaligned(input logic [1:0] addr_lsb);
    return addr_lsb != 2'b00;
  endfunction

endpackage

// File: rtl/mem_wb_reg.sv
// MEM/WB pipeline register; loads either the incoming bundle or a bubble every cycle.
module mem_wb_reg
  import core_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       bubble_i,
  input  wb_bundle_t bundle_i,
  output logic       valid_o,
  output wb_bundle_t bundle_o
);

  logic       valid_q;
  wb_bundle_t bundle_q;

  // A bubble zeroes the whole bundle so WB never sees stale write enables.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q  <= 1'b0;
      bundle_q <= '0;
    end else if (bubble_i) begin
      valid_q  <= 1'b0;
      bundle_q <= '0;
    end else begin
      valid_q  <= 1'b1;
      bundle_q <= bundle_i;
    end
  end

  assign valid_o  = valid_q;
  assign bundle_o = bundle_q;

endmodule

// File: rtl/mem_stage.sv
// MEM stage: data-memory access over a req/ack bus with upstream stall,
// access timeout, branch resolution and the MEM/WB handoff.
module mem_stage
  import core_pkg::*;
#(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 5
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            mem_re_in,
  input  logic            mem_we_in,
  input  logic            reg_file_write_in,
  input  logic            branch_in,
  input  logic            branch_instruction_in,
  input  logic [1:0]      select_mux_2_in,
  input  logic [1:0]      select_mux_4_in,
  input  logic [XLEN-1:0] reg_b_in,
  input  logic [4:0]      addr_rd_in,
  input  logic [XLEN-1:0] alu_in,
  input  logic [XLEN-1:0] add_pc_in,
  output logic            dmem_req,
  output logic            dmem_we,
  output logic [XLEN-1:0] dmem_addr,
  output logic [XLEN-1:0] dmem_wdata,
  input  logic [XLEN-1:0] dmem_rdata,
  input  logic            dmem_ack,
  output logic            stall,
  output logic            pc_src,
  output logic [XLEN-1:0] branch_target,
  output logic [1:0]      select_mux_2_out,
  output logic            wb_valid,
  output logic            reg_file_write_out,
  output logic [1:0]      select_mux_4_out,
  output logic [4:0]      addr_rd_out,
  output logic [XLEN-1:0] alu_out,
  output logic [XLEN-1:0] mem_data_out,
  output logic [XLEN-1:0] add_pc_out,
  output logic            bus_error,
  output logic            misalign_error
);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [XLEN-1:0]   addr_q, addr_d;
  logic [XLEN-1:0]   wdata_q, wdata_d;
  logic              we_q, we_d;
  logic              bus_err_q, bus_err_d;
  logic              misalign_q, misalign_d;
  logic              access;
  logic              wb_load;
  logic              wb_from_bus;
  wb_bundle_t        wb_in;
  wb_bundle_t        wb_out;

  // Load and store both set is treated as a store via we_d = mem_we_in.
  assign access = mem_re_in | mem_we_in;

  always_comb begin
    // NOTE: every next-state value gets its hold value first, so no branch can infer a latch.
    state_d     = state_q;
    cnt_d       = cnt_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    we_d        = we_q;
    bus_err_d   = bus_err_q;
    misalign_d  = misalign_q;
    stall       = 1'b0;
    wb_load     = 1'b0;
    wb_from_bus = 1'b0;
    case (state_q)
      IDLE: begin
        if (!access) begin
          wb_load = 1'b1;
        end else if (misaligned(alu_in[1:0])) begin
          misalign_d = 1'b1;
        end else begin
          state_d = WAIT;
          addr_d  = alu_in;
          wdata_d = reg_b_in;
          we_d    = mem_we_in;
          cnt_d   = '0;
          stall   = 1'b1;
        end
      end
      WAIT: begin
        if (dmem_ack) begin
          state_d     = IDLE;
          cnt_d       = '0;
          wb_load     = 1'b1;
          wb_from_bus = 1'b1;
        end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          state_d   = IDLE;
          cnt_d     = '0;
          bus_err_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
          stall = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      we_q       <= 1'b0;
      bus_err_q  <= 1'b0;
      misalign_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      we_q       <= we_d;
      bus_err_q  <= bus_err_d;
      misalign_q <= misalign_d;
    end
  end

  always_comb begin
    wb_in.reg_file_write = reg_file_write_in & ~(wb_from_bus & we_q);
    wb_in.select_mux_4   = select_mux_4_in;
    wb_in.addr_rd        = addr_rd_in;
    wb_in.alu            = alu_in;
    wb_in.mem_data       = (wb_from_bus && !we_q) ? dmem_rdata : '0;
    wb_in.add_pc         = add_pc_in;
  end

  mem_wb_reg u_mem_wb (
    .clk      (clk),
    .reset    (reset),
    .bubble_i (~wb_load),
    .bundle_i (wb_in),
    .valid_o  (wb_valid),
    .bundle_o (wb_out)
  );

  assign dmem_req   = (state_q == WAIT);
  assign dmem_we    = dmem_req & we_q;
  assign dmem_addr  = addr_q;
  assign dmem_wdata = wdata_q;

  // Branches resolve only when no access is in flight.
  assign pc_src           = branch_instruction_in & branch_in & (state_q == IDLE);
  assign branch_target    = add_pc_in;
  assign select_mux_2_out = select_mux_2_in;

  assign reg_file_write_out = wb_out.reg_file_write;
  assign select_mux_4_out   = wb_out.select_mux_4;
  assign addr_rd_out        = wb_out.addr_rd;
  assign alu_out            = wb_out.alu;
  assign mem_data_out       = wb_out.mem_data;
  assign add_pc_out         = wb_out.add_pc;
  assign bus_error          = bus_err_q;
  assign misalign_error     = misalign_q;

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: vector table, directed multi-cycle cases,
// and randomized instructions against a transaction-level model with a bus memory.
module tb_mem_stage;
  import core_pkg::*;

  localparam int TIMEOUT = 16;

  logic        clk = 1'b0;
  logic        reset;
  logic        mem_re_in, mem_we_in, reg_file_write_in, branch_in, branch_instruction_in;
  logic [1:0]  select_mux_2_in, select_mux_4_in;
  logic [31:0] reg_b_in, alu_in, add_pc_in;
  logic [4:0]  addr_rd_in;
  logic        dmem_req, dmem_we, dmem_ack;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic        stall, pc_src, wb_valid, reg_file_write_out, bus_error, misalign_error;
  logic [31:0] branch_target, alu_out, mem_data_out, add_pc_out;
  logic [1:0]  select_mux_2_out, select_mux_4_out;
  logic [4:0]  addr_rd_out;

  mem_stage #(.TIMEOUT(TIMEOUT), .CNT_W(5)) dut (
    .clk                   (clk),
    .reset                 (reset),
    .mem_re_in             (mem_re_in),
    .mem_we_in             (mem_we_in),
    .reg_file_write_in     (reg_file_write_in),
    .branch_in             (branch_in),
    .branch_instruction_in (branch_instruction_in),
    .select_mux_2_in       (select_mux_2_in),
    .select_mux_4_in       (select_mux_4_in),
    .reg_b_in              (reg_b_in),
    .addr_rd_in            (addr_rd_in),
    .alu_in                (alu_in),
    .add_pc_in             (add_pc_in),
    .dmem_req              (dmem_req),
    .dmem_we               (dmem_we),
    .dmem_addr             (dmem_addr),
    .dmem_wdata            (dmem_wdata),
    .dmem_rdata            (dmem_rdata),
    .dmem_ack              (dmem_ack),
    .stall                 (stall),
    .pc_src                (pc_src),
    .branch_target         (branch_target),
    .select_mux_2_out      (select_mux_2_out),
    .wb_valid              (wb_valid),
    .reg_file_write_out    (reg_file_write_out),
    .select_mux_4_out      (select_mux_4_out),
    .addr_rd_out           (addr_rd_out),
    .alu_out               (alu_out),
    .mem_data_out          (mem_data_out),
    .add_pc_out            (add_pc_out),
    .bus_error             (bus_error),
    .misalign_error        (misalign_error)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        re, we, rfw, bi, br;
    logic [1:0]  sel2, sel4;
    logic [31:0] regb, alu, add_pc;
    logic [4:0]  rd;
  } op_t;

  typedef struct {
    op_t         op;
    logic        exp_pc, exp_stall, exp_valid, exp_rfw, exp_mis;
    logic [31:0] exp_alu;
  } vec_t;

  int          checks = 0;
  int          errors = 0;
  logic        m_bus_err = 1'b0;
  logic        m_misalign = 1'b0;
  logic [31:0] bus_mem   [256];
  logic [31:0] model_mem [256];
  vec_t        vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic op_t mk(input logic re, input logic we, input logic rfw, input logic bi,
                             input logic br, input logic [31:0] alu, input logic [4:0] rd,
                             input logic [31:0] add_pc);
    op_t o;
    o.re = re; o.we = we; o.rfw = rfw; o.bi = bi; o.br = br;
    o.sel2 = 2'b01; o.sel4 = WB_ALU; o.regb = 32'h0;
    o.alu = alu; o.rd = rd; o.add_pc = add_pc;
    return o;
  endfunction

  task automatic drive(input op_t o);
    mem_re_in = o.re; mem_we_in = o.we; reg_file_write_in = o.rfw;
    branch_instruction_in = o.bi; branch_in = o.br;
    select_mux_2_in = o.sel2; select_mux_4_in = o.sel4;
    reg_b_in = o.regb; alu_in = o.alu; addr_rd_in = o.rd; add_pc_in = o.add_pc;
  endtask

  task automatic add_vec(input op_t o, input logic pc, input logic st, input logic vld,
                         input logic rfw, input logic [31:0] alu, input logic mis);
    vec_t v;
    v.op = o; v.exp_pc = pc; v.exp_stall = st; v.exp_valid = vld;
    v.exp_rfw = rfw; v.exp_alu = alu; v.exp_mis = mis;
    vecs.push_back(v);
  endtask

  // One instruction through the stage; lat = WAIT cycle carrying ack, 0 = never.
  // Called and returns at 1 time unit after a rising edge.
  task automatic run_op(input op_t o, input int lat, input string tag);
    logic        acc, al, acked, bus_ok;
    int          stalls, exp_stalls;
    logic [31:0] exp_data;
    acc = o.re | o.we;
    al  = (o.alu[1:0] == 2'b00);
    drive(o);
    @(negedge clk);
    check({tag, ":pc_src"}, pc_src, o.bi & o.br);
    check({tag, ":target"}, branch_target, o.add_pc);
    check({tag, ":sel2"}, select_mux_2_out, o.sel2);
    if (!acc || !al) begin
      check({tag, ":stall"}, stall, 1'b0);
      @(posedge clk); #1;
      if (!acc) begin
        check({tag, ":valid"}, wb_valid, 1'b1);
        check({tag, ":rfw"}, reg_file_write_out, o.rfw);
        check({tag, ":sel4"}, select_mux_4_out, o.sel4);
        check({tag, ":rd"}, addr_rd_out, o.rd);
        check({tag, ":alu"}, alu_out, o.alu);
        check({tag, ":add_pc"}, add_pc_out, o.add_pc);
        check({tag, ":mdata"}, mem_data_out, 32'h0);
      end else begin
        m_misalign = 1'b1;
        check({tag, ":mis_valid"}, wb_valid, 1'b0);
        check({tag, ":mis_rfw"}, reg_file_write_out, 1'b0);
        check({tag, ":mis_req"}, dmem_req, 1'b0);
      end
    end else begin
      stalls   = (stall === 1'b1) ? 1 : 0;
      bus_ok   = 1'b1;
      acked    = 1'b0;
      exp_data = o.we ? 32'h0 : model_mem[o.alu[9:2]];
      for (int k = 1; k <= TIMEOUT; k++) begin
        @(posedge clk); #1;
        if (k == lat) begin
          dmem_ack   = 1'b1;
          dmem_rdata = bus_mem[dmem_addr[9:2]];
        end else begin
          dmem_ack   = 1'b0;
          dmem_rdata = $urandom;
        end
        @(negedge clk);
        if (!(dmem_req === 1'b1 && dmem_addr === o.alu && dmem_we === o.we &&
              (!o.we || dmem_wdata === o.regb)))
          bus_ok = 1'b0;
        if (stall === 1'b1) stalls++;
        if (k == lat) begin
          acked = 1'b1;
          if (dmem_we === 1'b1) bus_mem[dmem_addr[9:2]] = dmem_wdata;
          break;
        end
      end
      @(posedge clk); #1;
      dmem_ack   = 1'b0;
      exp_stalls = acked ? lat : TIMEOUT;
      check({tag, ":stall_cycles"}, stalls, exp_stalls);
      check({tag, ":bus_hold"}, bus_ok, 1'b1);
      check({tag, ":req_drop"}, dmem_req, 1'b0);
      if (acked) begin
        if (o.we) model_mem[o.alu[9:2]] = o.regb;
        check({tag, ":valid"}, wb_valid, 1'b1);
        check({tag, ":rfw"}, reg_file_write_out, o.rfw & ~o.we);
        check({tag, ":mdata"}, mem_data_out, exp_data);
        check({tag, ":alu"}, alu_out, o.alu);
        check({tag, ":rd"}, addr_rd_out, o.rd);
        check({tag, ":sel4"}, select_mux_4_out, o.sel4);
        check({tag, ":add_pc"}, add_pc_out, o.add_pc);
      end else begin
        m_bus_err = 1'b1;
        check({tag, ":tmo_valid"}, wb_valid, 1'b0);
        check({tag, ":tmo_rfw"}, reg_file_write_out, 1'b0);
      end
    end
    check({tag, ":bus_error"}, bus_error, m_bus_err);
    check({tag, ":misalign"}, misalign_error, m_misalign);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

  initial begin
    op_t o;
    op_t nop;
    int  kind, r, lat;

    nop = mk(0, 0, 0, 0, 0, 32'h0, 5'd0, 32'h0);
    for (int i = 0; i < 256; i++) begin
      bus_mem[i]   = $urandom;
      model_mem[i] = bus_mem[i];
    end

    reset = 1'b1; dmem_ack = 1'b0; dmem_rdata = 32'h0;
    drive(nop);
    #1;
    check("rst:valid", wb_valid, 1'b0);
    check("rst:req", dmem_req, 1'b0);
    check("rst:stall", stall, 1'b0);
    check("rst:alu", alu_out, 32'h0);
    check("rst:rfw", reg_file_write_out, 1'b0);
    check("rst:bus_error", bus_error, 1'b0);
    check("rst:misalign", misalign_error, 1'b0);
    repeat (2) @(posedge clk);
    @(negedge clk); reset = 1'b0;
    @(posedge clk); #1;

    // Single-cycle vectors: ALU ops, branches, misaligned accesses.
    add_vec(mk(0, 0, 1, 0, 0, 32'h1234, 5'd5, 32'h0),  0, 0, 1, 1, 32'h1234, 0);
    add_vec(mk(0, 0, 0, 1, 1, 32'h0,    5'd0, 32'h80), 1, 0, 1, 0, 32'h0,    0);
    add_vec(mk(0, 0, 0, 1, 0, 32'h0,    5'd0, 32'h80), 0, 0, 1, 0, 32'h0,    0);
    add_vec(mk(0, 0, 1, 0, 1, 32'h55,   5'd3, 32'h84), 0, 0, 1, 1, 32'h55,   0);
    add_vec(mk(1, 0, 1, 0, 0, 32'h102,  5'd7, 32'h0),  0, 0, 0, 0, 32'h0,    1);
    add_vec(mk(0, 0, 1, 0, 0, 32'h77,   5'd2, 32'h0),  0, 0, 1, 1, 32'h77,   1);
    add_vec(mk(0, 1, 0, 0, 0, 32'h43,   5'd0, 32'h0),  0, 0, 0, 0, 32'h0,    1);
    foreach (vecs[i]) begin
      drive(vecs[i].op);
      @(negedge clk);
      check($sformatf("tbl%0d:pc_src", i), pc_src, vecs[i].exp_pc);
      check($sformatf("tbl%0d:target", i), branch_target, vecs[i].op.add_pc);
      check($sformatf("tbl%0d:stall", i), stall, vecs[i].exp_stall);
      check($sformatf("tbl%0d:req", i), dmem_req, 1'b0);
      @(posedge clk); #1;
      check($sformatf("tbl%0d:valid", i), wb_valid, vecs[i].exp_valid);
      check($sformatf("tbl%0d:rfw", i), reg_file_write_out, vecs[i].exp_rfw);
      check($sformatf("tbl%0d:misalign", i), misalign_error, vecs[i].exp_mis);
      if (vecs[i].exp_valid) begin
        check($sformatf("tbl%0d:alu", i), alu_out, vecs[i].exp_alu);
        check($sformatf("tbl%0d:rd", i), addr_rd_out, vecs[i].op.rd);
      end
    end
    m_misalign = 1'b1;

    // Load at 0x100, ack on the third WAIT cycle.
    bus_mem[64] = 32'hDEADBEEF; model_mem[64] = 32'hDEADBEEF;
    o = mk(1, 0, 1, 0, 0, 32'h100, 5'd9, 32'h104); o.sel4 = WB_MEM;
    run_op(o, 3, "load3");
    check("load3:deadbeef", mem_data_out, 32'hDEADBEEF);

    // Store to 0x40, ack in the first WAIT cycle; then read it back.
    o = mk(0, 1, 1, 0, 0, 32'h40, 5'd4, 32'h0); o.regb = 32'hCAFEF00D;
    run_op(o, 1, "store1");
    check("store1:mem", bus_mem[16], 32'hCAFEF00D);
    run_op(mk(1, 0, 1, 0, 0, 32'h40, 5'd6, 32'h0), 2, "ldback");
    check("ldback:data", mem_data_out, 32'hCAFEF00D);

    // Ack on the very last WAIT cycle still completes; load+store acts as a store.
    run_op(mk(1, 0, 1, 0, 0, 32'h8, 5'd1, 32'h0), TIMEOUT, "ld_edge");
    o = mk(1, 1, 1, 0, 0, 32'hC, 5'd1, 32'h0); o.regb = 32'h13579BDF;
    run_op(o, 2, "both");

    // Timeout, then a late ack during an unrelated ALU op is ignored.
    run_op(mk(1, 0, 1, 0, 0, 32'h200, 5'd8, 32'h0), 0, "tmo");
    dmem_ack = 1'b1; dmem_rdata = 32'hFFFFFFFF;
    run_op(mk(0, 0, 1, 0, 0, 32'h99, 5'd3, 32'h0), 0, "late_ack");
    check("late_ack:req", dmem_req, 1'b0);
    dmem_ack = 1'b0;

    // Reset in the middle of WAIT abandons the access and clears sticky flags.
    drive(mk(1, 0, 1, 0, 0, 32'h10, 5'd2, 32'h0));
    @(posedge clk); #1;
    @(negedge clk);
    check("rstw:pre_req", dmem_req, 1'b1);
    #2;
    reset = 1'b1;
    drive(nop);
    #1;
    check("rstw:req", dmem_req, 1'b0);
    check("rstw:stall", stall, 1'b0);
    check("rstw:valid", wb_valid, 1'b0);
    check("rstw:rfw", reg_file_write_out, 1'b0);
    check("rstw:mdata", mem_data_out, 32'h0);
    check("rstw:bus_error", bus_error, 1'b0);
    check("rstw:misalign", misalign_error, 1'b0);
    m_bus_err = 1'b0; m_misalign = 1'b0;
    @(negedge clk); reset = 1'b0;
    @(posedge clk); #1;
    check("rstw:post_req", dmem_req, 1'b0);
    check("rstw:post_valid", wb_valid, 1'b1);

    // Randomized instruction stream.
    for (int n = 0; n < 300; n++) begin
      o = nop;
      o.rfw = 1'($urandom); o.sel2 = 2'($urandom); o.sel4 = 2'($urandom);
      o.rd = 5'($urandom); o.regb = $urandom; o.add_pc = $urandom;
      o.alu = {22'd0, 8'($urandom), 2'b00};
      kind = $urandom_range(0, 9);
      case (kind)
        0, 1, 2: o.alu = $urandom;
        3:       begin o.bi = 1'b1; o.br = 1'($urandom); o.alu = $urandom; end
        4, 5:    o.re = 1'b1;
        6, 7:    o.we = 1'b1;
        8:       begin o.re = 1'($urandom); o.we = ~o.re; o.alu[1:0] = 2'($urandom_range(1, 3)); end
        default: begin o.re = 1'b1; o.we = 1'b1; end
      endcase
      r   = $urandom_range(0, 19);
      lat = (r == 0) ? 0 : (r == 1) ? TIMEOUT : $urandom_range(1, 5);
      run_op(o, lat, $sformatf("rnd%0d", n));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
